// File: rtl/alu_result_stage.sv
// Writeback stage behind the 4-bit ALU: a small first-word-fall-through FIFO of results,
// plus the Z/N/V flag register and a saturating ADD/SUB overflow counter.
module alu_result_stage #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_err,
  input  logic [1:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic [1:0]       out_op,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v,
  output logic [CNT_W-1:0] ovf_cnt
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  logic [WIDTH-1:0] data_mem [DEPTH];
  logic             err_mem  [DEPTH];
  logic [1:0]       op_mem   [DEPTH];

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             flag_z_q, flag_z_d;
  logic             flag_n_q, flag_n_d;
  logic             flag_v_q, flag_v_d;
  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
  logic             push, pop;

  // Ready depends only on the registered count, so a pop never frees a slot the same cycle.
  assign in_ready  = (count_q < FullCnt);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    flag_z_d  = flag_z_q;
    flag_n_d  = flag_n_q;
    flag_v_d  = flag_v_q;
    ovf_cnt_d = ovf_cnt_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Flags follow the incoming result; N/V only meaningful for arithmetic ops.
    if (push) begin
      flag_z_d = (alu_out == '0);
      if (alu_op[1]) begin
        flag_n_d = alu_out[WIDTH-1];
        flag_v_d = alu_err;
        if (alu_err && (ovf_cnt_q != '1)) ovf_cnt_d = ovf_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      flag_z_q  <= 1'b0;
      flag_n_q  <= 1'b0;
      flag_v_q  <= 1'b0;
      ovf_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      flag_z_q  <= flag_z_d;
      flag_n_q  <= flag_n_d;
      flag_v_q  <= flag_v_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  // Storage needs no reset: contents are only visible while count is non-zero.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      data_mem[wr_ptr_q] <= alu_out;
      err_mem[wr_ptr_q]  <= alu_err;
      op_mem[wr_ptr_q]   <= alu_op;
    end
  end

  assign out_data = out_valid ? data_mem[rd_ptr_q] : '0;
  assign out_err  = out_valid ? err_mem[rd_ptr_q]  : 1'b0;
  assign out_op   = out_valid ? op_mem[rd_ptr_q]   : 2'b00;
  assign flag_z   = flag_z_q;
  assign flag_n   = flag_n_q;
  assign flag_v   = flag_v_q;
  assign ovf_cnt  = ovf_cnt_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: directed scenarios then random traffic, checked against a
// queue-based reference model of the result FIFO, flags and overflow counter.
module tb_alu_result_stage;

  localparam int WIDTH = 4;
  localparam int DEPTH = 2;
  localparam int CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] alu_out = '0;
  logic             alu_err = 1'b0;
  logic [1:0]       alu_op = 2'b00;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_err;
  logic [1:0]       out_op;
  logic             flag_z, flag_n, flag_v;
  logic [CNT_W-1:0] ovf_cnt;

  alu_result_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_out   (alu_out),
    .alu_err   (alu_err),
    .alu_op    (alu_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .out_op    (out_op),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .flag_v    (flag_v),
    .ovf_cnt   (ovf_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int d;
    int e;
    int op;
  } entry_t;

  // Reference model state
  entry_t m_q[$];
  int     m_z, m_n, m_v, m_cnt;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic check_all(input string tag);
    int ev;
    ev = (m_q.size() != 0) ? 1 : 0;
    chk({tag, ".out_valid"}, int'(out_valid), ev);
    chk({tag, ".in_ready"},  int'(in_ready), (m_q.size() < DEPTH) ? 1 : 0);
    chk({tag, ".out_data"},  int'(out_data), ev ? m_q[0].d : 0);
    chk({tag, ".out_err"},   int'(out_err), ev ? m_q[0].e : 0);
    chk({tag, ".out_op"},    int'(out_op), ev ? m_q[0].op : 0);
    chk({tag, ".flag_z"},    int'(flag_z), m_z);
    chk({tag, ".flag_n"},    int'(flag_n), m_n);
    chk({tag, ".flag_v"},    int'(flag_v), m_v);
    chk({tag, ".ovf_cnt"},   int'(ovf_cnt), m_cnt);
  endtask

  // One clock: drive inputs at the falling edge, advance the model, check after the rising edge.
  task automatic step(input string tag, input bit rs, input bit v, input int d, input bit e,
                      input int op, input bit r, input bit do_check = 1'b1);
    bit     m_push, m_pop;
    entry_t ent;
    @(negedge clk);
    rst       = rs;
    in_valid  = v;
    alu_out   = WIDTH'(d);
    alu_err   = e;
    alu_op    = 2'(op);
    out_ready = r;
    m_push = !rs && v && (m_q.size() < DEPTH);
    m_pop  = !rs && r && (m_q.size() > 0);
    @(posedge clk);
    #1;
    if (rs) begin
      m_q.delete();
      m_z = 0; m_n = 0; m_v = 0; m_cnt = 0;
    end else begin
      if (m_pop) void'(m_q.pop_front());
      if (m_push) begin
        ent.d = d; ent.e = int'(e); ent.op = op;
        m_q.push_back(ent);
        m_z = (d == 0) ? 1 : 0;
        if (op >= 2) begin
          m_n = (d >> (WIDTH - 1)) & 1;
          m_v = int'(e);
          if (e && m_cnt < CNT_MAX) m_cnt++;
        end
      end
    end
    if (do_check) check_all(tag);
  endtask

  initial begin
    m_z = 0; m_n = 0; m_v = 0; m_cnt = 0;

    // Reset state
    step("rst0", 1, 0, 0, 0, 0, 0);
    step("rst1", 1, 0, 0, 0, 0, 0);
    chk("rst.out_data_zero", int'(out_data), 0);
    chk("rst.in_ready_one", int'(in_ready), 1);

    // ADD overflow with consumer stalled
    step("add_ovf", 0, 1, 8, 1, 2, 0);
    chk("add_ovf.data8", int'(out_data), 8);
    chk("add_ovf.cnt1", int'(ovf_cnt), 1);
    step("drain", 0, 0, 0, 0, 0, 1);

    // NAND 0, XOR 5, dropped third push; N/V hold
    step("nand0", 0, 1, 0, 0, 0, 0);
    chk("nand0.z", int'(flag_z), 1);
    step("xor5", 0, 1, 5, 0, 1, 0);
    chk("xor5.z", int'(flag_z), 0);
    chk("xor5.in_ready", int'(in_ready), 0);
    step("drop", 0, 1, 9, 1, 2, 0);
    chk("drop.head0", int'(out_data), 0);

    // Full with push and pop together: only the pop happens
    step("full_pp", 0, 1, 3, 0, 2, 1);
    chk("full_pp.head5", int'(out_data), 5);
    chk("full_pp.in_ready", int'(in_ready), 1);

    // count=1: push SUB 0 plus pop
    step("sub0_pp", 0, 1, 0, 0, 3, 1);
    chk("sub0_pp.op", int'(out_op), 3);
    step("pop_last", 0, 0, 0, 0, 0, 1);

    // Drive the overflow counter to saturation and beyond
    for (int i = 0; i < CNT_MAX + 3; i++) step("sat", 0, 1, 9, 1, 3, 1, 1'b0);
    check_all("sat_end");
    chk("sat.cnt_max", int'(ovf_cnt), CNT_MAX);

    // Reset while non-empty
    step("fill", 0, 1, 7, 0, 2, 0);
    step("mid_rst", 1, 1, 4, 1, 2, 0);
    chk("mid_rst.valid0", int'(out_valid), 0);

    // Random traffic, including non-arithmetic ops with err=1 that must be ignored
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 59) == 0), $urandom_range(0, 1) == 1,
           int'($urandom_range(0, 15)), $urandom_range(0, 1) == 1,
           int'($urandom_range(0, 3)), $urandom_range(0, 2) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
